// File: rtl/starfield_scroll_ctrl.sv
// Frame-synchronous vertical scroll controller for the starfield background.
// All state moves only on the falling edge of vsync, so the offset never changes mid-frame.
module starfield_scroll_ctrl #(
  parameter int DIV_W          = 4,
  parameter int WARP_STEP      = 4,
  parameter int TWINKLE_FRAMES = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             vsync,
  input  logic             run_req,
  input  logic [DIV_W-1:0] speed,
  input  logic             warp_start,
  input  logic [7:0]       warp_frames,
  output logic [6:0]       offset,
  output logic             frame_tick,
  output logic             warping,
  output logic             twinkle
);

  localparam int              TWK_W    = (TWINKLE_FRAMES > 1) ? $clog2(TWINKLE_FRAMES) : 1;
  localparam logic [6:0]      WARP_INC = 7'(WARP_STEP);
  localparam logic [TWK_W-1:0] TWK_LAST = TWK_W'(TWINKLE_FRAMES - 1);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    WARP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             vsync_q;
  logic             vs_fall;
  logic             warp_go;
  logic [6:0]       offset_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [7:0]       warp_cnt, warp_cnt_nxt;
  logic             warp_pend, warp_pend_nxt;
  logic [TWK_W-1:0] twk_cnt;

  assign vs_fall = vsync_q & ~vsync;
  assign warp_go = warp_pend | warp_start;

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    offset_nxt    = offset;
    div_cnt_nxt   = div_cnt;
    warp_cnt_nxt  = warp_cnt;
    warp_pend_nxt = warp_pend;

    case (state)
      PAUSED: begin
        if (vs_fall && run_req) begin
          state_nxt   = RUN;
          div_cnt_nxt = '0;
        end
      end

      RUN: begin
        // A warp request is remembered until the next frame edge consumes it.
        if (warp_start) warp_pend_nxt = 1'b1;
        if (vs_fall) begin
          if (!run_req) begin
            state_nxt     = PAUSED;
            div_cnt_nxt   = '0;
            warp_pend_nxt = 1'b0;
          end else if (warp_go) begin
            state_nxt     = WARP;
            warp_cnt_nxt  = (warp_frames == 8'd0) ? 8'd0 : warp_frames - 8'd1;
            warp_pend_nxt = 1'b0;
          end else if (div_cnt >= speed) begin
            offset_nxt  = offset + 7'd1;
            div_cnt_nxt = '0;
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
      end

      WARP: begin
        if (vs_fall) begin
          offset_nxt = offset + WARP_INC;
          if (warp_cnt == 8'd0) begin
            state_nxt   = RUN;
            div_cnt_nxt = '0;
          end else begin
            warp_cnt_nxt = warp_cnt - 8'd1;
          end
        end
      end

      default: state_nxt = PAUSED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= PAUSED;
      vsync_q    <= 1'b1;
      offset     <= '0;
      frame_tick <= 1'b0;
      warping    <= 1'b0;
      div_cnt    <= '0;
      warp_cnt   <= '0;
      warp_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      vsync_q    <= vsync;
      offset     <= offset_nxt;
      frame_tick <= vs_fall;
      warping    <= (state_nxt == WARP);
      div_cnt    <= div_cnt_nxt;
      warp_cnt   <= warp_cnt_nxt;
      warp_pend  <= warp_pend_nxt;
    end
  end

  // Twinkle phase advances on every frame edge regardless of scroll state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      twk_cnt <= '0;
      twinkle <= 1'b0;
    end else if (vs_fall) begin
      if (twk_cnt == TWK_LAST) begin
        twk_cnt <= '0;
        twinkle <= ~twinkle;
      end else begin
        twk_cnt <= twk_cnt + TWK_W'(1);
      end
    end
  end

endmodule
